// File: rtl/gpr_pkg.sv
// gpr_pkg: shared register-file defaults, address-width helper and zero-register index
package gpr_pkg;
  localparam int GPR_WIDTH_DEF   = 32;
  localparam int GPR_DEPTH_DEF   = 32;
  localparam int GPR_OVF_REG_DEF = 30;
  localparam int ZERO_REG        = 0;
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/gpr_file_param_if.sv
// gpr_file_param_if: decode/write-back bus to the register file (write port, overflow flag, packed read ports)
interface gpr_file_param_if
  import gpr_pkg::*;
#(
  parameter int WIDTH  = GPR_WIDTH_DEF,
  parameter int DEPTH  = GPR_DEPTH_DEF,
  parameter int NUM_RD = 2
);
  localparam int ADDR_W = addr_w(DEPTH);
  logic                     gpr_wr;
  logic [ADDR_W-1:0]        wr_addr;
  logic [WIDTH-1:0]         wr_data;
  logic                     ovf_wr;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*WIDTH-1:0]  rd_data;
  logic                     ovf_flag;
  modport master (output gpr_wr, wr_addr, wr_data, ovf_wr, rd_addr, input rd_data, ovf_flag);
  modport slave  (input gpr_wr, wr_addr, wr_data, ovf_wr, rd_addr, output rd_data, ovf_flag);
endinterface

// File: rtl/gpr_rd_port.sv
// gpr_rd_port: one combinational read port with zero/range masking; GPR_BYPASS_EN adds write-to-read forwarding
module gpr_rd_port
  import gpr_pkg::*;
#(
  parameter int WIDTH   = GPR_WIDTH_DEF,
  parameter int DEPTH   = GPR_DEPTH_DEF,
  parameter int OVF_REG = GPR_OVF_REG_DEF,
  parameter int ADDR_W  = addr_w(DEPTH)
) (
  input  logic [ADDR_W-1:0]              i_rd_addr,
  input  logic [(1<<ADDR_W)*WIDTH-1:0]   i_regs,
  input  logic                           i_wr_en,
  input  logic [ADDR_W-1:0]              i_wr_addr,
  input  logic [WIDTH-1:0]               i_wr_data,
  input  logic                           i_ovf_en,
  input  logic [WIDTH-1:0]               i_ovf_data,
  output logic [WIDTH-1:0]               o_rd_data
);
  logic             w_in_range;
  logic [WIDTH-1:0] w_stored;
  assign w_in_range = (i_rd_addr != ADDR_W'(ZERO_REG)) && ({1'b0, i_rd_addr} < (ADDR_W+1)'(DEPTH));
  assign w_stored   = w_in_range ? i_regs[i_rd_addr*WIDTH +: WIDTH] : '0;
`ifdef GPR_BYPASS_EN
  // i_wr_en already excludes reg 0, out-of-range targets and overflow cycles
  assign o_rd_data = (i_wr_en && i_wr_addr == i_rd_addr) ? i_wr_data :
                     (i_ovf_en && i_rd_addr == ADDR_W'(OVF_REG)) ? i_ovf_data : w_stored;
`else
  logic w_unused;
  assign w_unused  = ^{i_wr_en, i_wr_addr, i_wr_data, i_ovf_en, i_ovf_data};
  assign o_rd_data = w_stored;
`endif
endmodule

// File: rtl/gpr_file_param.sv
// gpr_file_param: parametrised GPR file, reg 0 hard-wired to zero, sticky overflow bit; GPR_BYPASS_EN enables forwarding
module gpr_file_param
  import gpr_pkg::*;
#(
  parameter int WIDTH   = GPR_WIDTH_DEF,
  parameter int DEPTH   = GPR_DEPTH_DEF,
  parameter int NUM_RD  = 2,
  parameter int OVF_REG = GPR_OVF_REG_DEF
) (
  input logic             clk,
  input logic             rst,
  gpr_file_param_if.slave bus
);
  localparam int ADDR_W = addr_w(DEPTH);
  localparam int NSLOT  = 1 << ADDR_W;
  logic [WIDTH-1:0]       r_regs [1:DEPTH-1];
  logic [NSLOT*WIDTH-1:0] w_regs;
  logic                   w_wr_en;
  logic                   w_ovf_en;
  logic [WIDTH-1:0]       w_ovf_data;
  // an overflowing result never commits; reset also blanks forwarding
  assign w_wr_en    = rst & bus.gpr_wr & ~bus.ovf_wr & (bus.wr_addr != ADDR_W'(ZERO_REG)) &
                      ({1'b0, bus.wr_addr} < (ADDR_W+1)'(DEPTH));
  assign w_ovf_en   = rst & bus.ovf_wr;
  assign w_ovf_data = r_regs[OVF_REG] | WIDTH'(1);
  // storage: overflow sets bit 0 of OVF_REG, otherwise a qualified write lands in its register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      for (int i = 1; i < DEPTH; i++) r_regs[i] <= '0;
    else
      for (int i = 1; i < DEPTH; i++)
        if (w_ovf_en && i == OVF_REG) r_regs[i][0] <= 1'b1;
        else if (w_wr_en && bus.wr_addr == ADDR_W'(i)) r_regs[i] <= bus.wr_data;
  end
  // flatten storage into a power-of-two slot vector; slot 0 and unused slots read as zero
  always_comb begin
    w_regs = '0;
    for (int i = 1; i < DEPTH; i++) w_regs[i*WIDTH +: WIDTH] = r_regs[i];
  end
  genvar k;
  for (k = 0; k < NUM_RD; k++) begin : g_rd
    gpr_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OVF_REG(OVF_REG), .ADDR_W(ADDR_W)) u_port (
      .i_rd_addr (bus.rd_addr[k*ADDR_W +: ADDR_W]),
      .i_regs    (w_regs),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .i_ovf_en  (w_ovf_en),
      .i_ovf_data(w_ovf_data),
      .o_rd_data (bus.rd_data[k*WIDTH +: WIDTH])
    );
  end
  assign bus.ovf_flag = r_regs[OVF_REG][0];
endmodule

// File: tb/tb_gpr_file_param.sv
// tb_gpr_file_param: directed and randomized checks of two register-file configurations against an array model
module tb_gpr_file_param;
  import gpr_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  logic [31:0] m_d [32];
  logic [31:0] m_e [12];
  logic [31:0] got, want;
  gpr_file_param_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(2)) dif();
  gpr_file_param_if #(.WIDTH(32), .DEPTH(12), .NUM_RD(3)) eif();
  gpr_file_param #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .OVF_REG(30)) u_d (.clk(clk), .rst(rst), .bus(dif));
  gpr_file_param #(.WIDTH(32), .DEPTH(12), .NUM_RD(3), .OVF_REG(10)) u_e (.clk(clk), .rst(rst), .bus(eif));
  always #5 clk = ~clk;

  task automatic idle();
    dif.gpr_wr = 0; dif.ovf_wr = 0; dif.wr_addr = '0; dif.wr_data = '0; dif.rd_addr = '0;
    eif.gpr_wr = 0; eif.ovf_wr = 0; eif.wr_addr = '0; eif.wr_data = '0; eif.rd_addr = '0;
  endtask

  // reference: one clock edge of the register-file rules
  task automatic upd(input bit e, input logic gw, input int wa, input logic [31:0] wd, input logic ov);
    if (e) begin
      if (ov) m_e[10][0] = 1'b1;
      else if (gw && wa > 0 && wa < 12) m_e[wa] = wd;
    end else begin
      if (ov) m_d[30][0] = 1'b1;
      else if (gw && wa > 0 && wa < 32) m_d[wa] = wd;
    end
  endtask

  // reference: what a read port shows right now, given current stored state and bus inputs
  function automatic logic [31:0] exp_rd(input bit e, input int a);
    int dep = e ? 12 : 32;
    int ovr = e ? 10 : 30;
    logic gw = e ? eif.gpr_wr : dif.gpr_wr;
    logic ov = e ? eif.ovf_wr : dif.ovf_wr;
    int wa = e ? int'(eif.wr_addr) : int'(dif.wr_addr);
    logic [31:0] wd = e ? eif.wr_data : dif.wr_data;
    logic [31:0] v;
    if (a == 0 || a >= dep) return 32'h0;
    v = e ? m_e[a] : m_d[a];
`ifdef GPR_BYPASS_EN
    if (rst) begin
      if (ov && a == ovr) v = v | 32'h1;
      else if (gw && !ov && a == wa) v = wd;
    end
`else
    if (gw && ov && wa == ovr) v = v;
`endif
    return v;
  endfunction

  task automatic wr_d(input logic gw, input int wa, input logic [31:0] wd, input logic ov);
    dif.gpr_wr = gw; dif.wr_addr = 5'(wa); dif.wr_data = wd; dif.ovf_wr = ov;
    @(posedge clk); upd(0, gw, wa, wd, ov); #1;
    dif.gpr_wr = 0; dif.ovf_wr = 0;
  endtask

  task automatic wr_e(input logic gw, input int wa, input logic [31:0] wd, input logic ov);
    eif.gpr_wr = gw; eif.wr_addr = 4'(wa); eif.wr_data = wd; eif.ovf_wr = ov;
    @(posedge clk); upd(1, gw, wa, wd, ov); #1;
    eif.gpr_wr = 0; eif.ovf_wr = 0;
  endtask

  task automatic test_reset();
    idle();
    #5 rst = 0;
    dif.gpr_wr = 1; dif.wr_addr = 5'd1; dif.wr_data = 32'hDEADBEEF; dif.rd_addr = {5'd30, 5'd1};
    eif.gpr_wr = 1; eif.wr_addr = 4'd1; eif.wr_data = 32'hDEADBEEF; eif.rd_addr = {4'd10, 4'd5, 4'd1};
    #1;
    checks++; if (dif.rd_data !== 64'h0) begin errs++; $display("FAIL rst_rd_d got %h want 0", dif.rd_data); end
    checks++; if (dif.ovf_flag !== 1'b0) begin errs++; $display("FAIL rst_ovf_d got %b want 0", dif.ovf_flag); end
    checks++; if (eif.rd_data !== 96'h0) begin errs++; $display("FAIL rst_rd_e got %h want 0", eif.rd_data); end
    checks++; if (eif.ovf_flag !== 1'b0) begin errs++; $display("FAIL rst_ovf_e got %b want 0", eif.ovf_flag); end
    #14 rst = 1;
    dif.gpr_wr = 0; eif.gpr_wr = 0;
    for (int i = 0; i < 32; i++) m_d[i] = 32'h0;
    for (int i = 0; i < 12; i++) m_e[i] = 32'h0;
    #1;
    checks++; if (dif.rd_data[31:0] !== 32'h0) begin errs++; $display("FAIL rst_wr_discard_d got %h want 0", dif.rd_data[31:0]); end
    checks++; if (eif.rd_data[31:0] !== 32'h0) begin errs++; $display("FAIL rst_wr_discard_e got %h want 0", eif.rd_data[31:0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    wr_d(1, 1, 32'h80000001, 0);
    dif.rd_addr = {5'd0, 5'd1}; #1;
    checks++; if (dif.rd_data[31:0] !== 32'h80000001) begin errs++; $display("FAIL wr_r1 got %h want 80000001", dif.rd_data[31:0]); end
    checks++; if (dif.rd_data[63:32] !== 32'h0) begin errs++; $display("FAIL rd_r0 got %h want 0", dif.rd_data[63:32]); end
    wr_d(1, 0, 32'h12345678, 0);
    dif.rd_addr = {5'd1, 5'd0}; #1;
    checks++; if (dif.rd_data[31:0] !== 32'h0) begin errs++; $display("FAIL wr_r0 got %h want 0", dif.rd_data[31:0]); end
    checks++; if (dif.rd_data[63:32] !== 32'h80000001) begin errs++; $display("FAIL port1_r1 got %h want 80000001", dif.rd_data[63:32]); end
  endtask

  task automatic test_overflow();
    wr_d(1, 30, 32'hFFFF0000, 0);
    wr_d(1, 30, 32'h5, 1);
    dif.rd_addr = {5'd30, 5'd30}; #1;
    checks++; if (dif.rd_data[31:0] !== 32'hFFFF0001) begin errs++; $display("FAIL ovf_r30 got %h want FFFF0001", dif.rd_data[31:0]); end
    checks++; if (dif.ovf_flag !== 1'b1) begin errs++; $display("FAIL ovf_flag got %b want 1", dif.ovf_flag); end
  endtask

  task automatic test_ovf_suppress();
    wr_d(1, 2, 32'h80000000, 1);
    dif.rd_addr = {5'd30, 5'd2}; #1;
    checks++; if (dif.rd_data[31:0] !== 32'h0) begin errs++; $display("FAIL ovf_supp_r2 got %h want 0", dif.rd_data[31:0]); end
    checks++; if (dif.rd_data[63:32] !== 32'hFFFF0001) begin errs++; $display("FAIL ovf_supp_r30 got %h want FFFF0001", dif.rd_data[63:32]); end
    wr_d(1, 7, 32'h3, 0); #1;
    checks++; if (dif.ovf_flag !== 1'b1) begin errs++; $display("FAIL ovf_sticky got %b want 1", dif.ovf_flag); end
    wr_d(1, 30, 32'h0, 0); #1;
    checks++; if (dif.ovf_flag !== 1'b0) begin errs++; $display("FAIL ovf_clear got %b want 0", dif.ovf_flag); end
    checks++; if (dif.rd_data[63:32] !== 32'h0) begin errs++; $display("FAIL ovf_clear_r30 got %h want 0", dif.rd_data[63:32]); end
  endtask

  task automatic test_multi_port();
    wr_e(1, 5, 32'hA5A5A5A5, 0);
    eif.rd_addr = {4'd5, 4'd5, 4'd5}; #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (eif.rd_data[k*32 +: 32] !== 32'hA5A5A5A5) begin errs++; $display("FAIL multi_p%0d got %h want A5A5A5A5", k, eif.rd_data[k*32 +: 32]); end
    end
    eif.rd_addr = {4'd0, 4'd5, 4'd0}; #1;
    checks++; if (eif.rd_data !== {32'h0, 32'hA5A5A5A5, 32'h0}) begin errs++; $display("FAIL multi_zero got %h want 0/A5A5A5A5/0", eif.rd_data); end
    for (int a = 12; a < 16; a++) wr_e(1, a, 32'hBAD00000 | a, 0);
    wr_e(0, 3, 32'h1234, 1);
    checks++; if (eif.ovf_flag !== 1'b1) begin errs++; $display("FAIL e_ovf got %b want 1", eif.ovf_flag); end
    for (int a = 0; a < 16; a++) begin
      eif.rd_addr = {4'(a), 4'(a), 4'(a)}; #1;
      want = exp_rd(1, a);
      checks++; if (eif.rd_data !== {want, want, want}) begin errs++; $display("FAIL e_scan_%0d got %h want %h x3", a, eif.rd_data, want); end
    end
  endtask

  task automatic test_bypass();
    dif.rd_addr = {5'd30, 5'd3}; dif.gpr_wr = 1; dif.wr_addr = 5'd3; dif.wr_data = 32'h7; #1;
`ifdef GPR_BYPASS_EN
    want = 32'h7;
`else
    want = 32'h0;
`endif
    checks++; if (dif.rd_data[31:0] !== want) begin errs++; $display("FAIL byp_wr got %h want %h", dif.rd_data[31:0], want); end
    @(posedge clk); upd(0, 1, 3, 32'h7, 0); #1; dif.gpr_wr = 0;
    checks++; if (dif.rd_data[31:0] !== 32'h7) begin errs++; $display("FAIL byp_after got %h want 7", dif.rd_data[31:0]); end
    dif.ovf_wr = 1; dif.wr_addr = 5'd30; dif.wr_data = 32'hFF; dif.gpr_wr = 1; #1;
`ifdef GPR_BYPASS_EN
    want = 32'h1;
`else
    want = 32'h0;
`endif
    checks++; if (dif.rd_data[63:32] !== want) begin errs++; $display("FAIL byp_ovf got %h want %h", dif.rd_data[63:32], want); end
    checks++; if (dif.ovf_flag !== 1'b0) begin errs++; $display("FAIL byp_ovf_flag got %b want 0", dif.ovf_flag); end
    @(posedge clk); upd(0, 1, 30, 32'hFF, 1); #1; dif.ovf_wr = 0; dif.gpr_wr = 0;
    checks++; if (dif.ovf_flag !== 1'b1) begin errs++; $display("FAIL byp_ovf_after got %b want 1", dif.ovf_flag); end
    dif.rd_addr = {5'd30, 5'd0}; dif.gpr_wr = 1; dif.wr_addr = 5'd0; dif.wr_data = 32'hFF; #1;
    checks++; if (dif.rd_data[31:0] !== 32'h0) begin errs++; $display("FAIL byp_r0 got %h want 0", dif.rd_data[31:0]); end
    @(posedge clk); upd(0, 1, 0, 32'hFF, 0); #1; dif.gpr_wr = 0;
  endtask

  task automatic test_random();
    logic gwd, ovd, gwe, ove;
    int wad, wae;
    logic [31:0] wdd, wde;
    for (int n = 0; n < 400; n++) begin
      gwd = 1'($urandom_range(0, 1)); ovd = ($urandom_range(0, 7) == 0); wad = $urandom_range(0, 31); wdd = $urandom;
      gwe = 1'($urandom_range(0, 1)); ove = ($urandom_range(0, 7) == 0); wae = $urandom_range(0, 15); wde = $urandom;
      dif.gpr_wr = gwd; dif.ovf_wr = ovd; dif.wr_addr = 5'(wad); dif.wr_data = wdd; dif.rd_addr = 10'($urandom);
      eif.gpr_wr = gwe; eif.ovf_wr = ove; eif.wr_addr = 4'(wae); eif.wr_data = wde; eif.rd_addr = 12'($urandom);
      if ($urandom_range(0, 3) == 0) dif.rd_addr[4:0] = 5'(wad);
      if ($urandom_range(0, 3) == 0) eif.rd_addr[3:0] = 4'(wae);
      #1;
      for (int k = 0; k < 2; k++) begin
        got = dif.rd_data[k*32 +: 32]; want = exp_rd(0, int'(dif.rd_addr[k*5 +: 5]));
        checks++; if (got !== want) begin errs++; $display("FAIL rand_d n=%0d p%0d addr=%0d got %h want %h", n, k, dif.rd_addr[k*5 +: 5], got, want); end
      end
      for (int k = 0; k < 3; k++) begin
        got = eif.rd_data[k*32 +: 32]; want = exp_rd(1, int'(eif.rd_addr[k*4 +: 4]));
        checks++; if (got !== want) begin errs++; $display("FAIL rand_e n=%0d p%0d addr=%0d got %h want %h", n, k, eif.rd_addr[k*4 +: 4], got, want); end
      end
      checks++; if (dif.ovf_flag !== m_d[30][0]) begin errs++; $display("FAIL rand_ovf_d n=%0d got %b want %b", n, dif.ovf_flag, m_d[30][0]); end
      checks++; if (eif.ovf_flag !== m_e[10][0]) begin errs++; $display("FAIL rand_ovf_e n=%0d got %b want %b", n, eif.ovf_flag, m_e[10][0]); end
      @(posedge clk);
      upd(0, gwd, wad, wdd, ovd);
      upd(1, gwe, wae, wde, ove);
      #1;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write();
    test_overflow();
    test_ovf_suppress();
    test_multi_port();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
